// File: rtl/acc_pkg.sv
// Shared types and width helpers for the windowed accumulator family.
// Sum limits are returned as longint so callers can cast them to their own width.
package acc_pkg;

  typedef enum logic {
    ACC_WRAP = 1'b0,
    ACC_SAT  = 1'b1
  } acc_mode_e;

  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int cnt_w(input int win);
    return (win > 1) ? $clog2(win) : 1;
  endfunction

  function automatic longint sum_max(input int sum_w);
    return (longint'(1) << (sum_w - 1)) - 1;
  endfunction

  function automatic longint sum_min(input int sum_w);
    return -(longint'(1) << (sum_w - 1));
  endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Signed accumulate step: acc + sample at one guard bit, then clamp or wrap.
// Overflow is flagged in both modes so callers can track it independently of mode.
module acc_sat_add
  import acc_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int SUM_W = 16
) (
  input  logic signed [SUM_W-1:0] acc,
  input  logic signed [IN_W-1:0]  sample,
  input  acc_mode_e               mode,
  output logic signed [SUM_W-1:0] result,
  output logic                    overflow
);

  localparam int EXT_W = SUM_W + 1 - IN_W;
  localparam logic signed [SUM_W-1:0] SUM_HI = SUM_W'(sum_max(SUM_W));
  localparam logic signed [SUM_W-1:0] SUM_LO = SUM_W'(sum_min(SUM_W));

  logic [SUM_W:0] acc_ext;
  logic [SUM_W:0] smp_ext;
  logic [SUM_W:0] nxt;

  always_comb begin
    acc_ext  = {acc[SUM_W-1], acc};
    smp_ext  = {{EXT_W{sample[IN_W-1]}}, sample};
    nxt      = acc_ext + smp_ext;
    // guard bit disagreeing with the top result bit means the sum left the SUM_W range
    overflow = nxt[SUM_W] ^ nxt[SUM_W-1];
    result   = nxt[SUM_W-1:0];
    if (overflow && (mode == ACC_SAT)) begin
      result = nxt[SUM_W] ? SUM_LO : SUM_HI;
    end
  end

endmodule

// File: rtl/acc_bank.sv
// Multi-channel windowed accumulator: per-channel sums closed every WIN samples,
// with a registered one-cycle result pulse and per-channel sticky overflow.
module acc_bank
  import acc_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IN_W  = 8,
  parameter int SUM_W = 16,
  parameter int WIN   = 16,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [CH_W-1:0]         in_ch,
  input  logic signed [IN_W-1:0]  in,
  input  logic                    sat_en,
  input  logic                    clr,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [SUM_W-1:0] sum,
  output logic                    ovf,
  output logic [N_CH-1:0]         ovf_sticky
);

  localparam int CNT_W = cnt_w(WIN);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN - 1);
  localparam logic [CH_W:0]    N_CH_L   = (CH_W + 1)'(N_CH);

  logic signed [SUM_W-1:0] acc_q [N_CH];
  logic signed [SUM_W-1:0] acc_d [N_CH];
  logic [CNT_W-1:0]        cnt_q [N_CH];
  logic [CNT_W-1:0]        cnt_d [N_CH];
  logic [N_CH-1:0]         wovf_q, wovf_d;
  logic [N_CH-1:0]         sticky_q, sticky_d;

  logic                    out_valid_q, out_valid_d;
  logic [CH_W-1:0]         out_ch_q, out_ch_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic                    ovf_q, ovf_d;

  logic                    ch_ok;
  logic                    accept;
  logic                    win_close;
  logic signed [SUM_W-1:0] sel_acc;
  logic signed [SUM_W-1:0] add_res;
  logic                    add_ovf;
  acc_mode_e               mode;

  assign mode   = acc_mode_e'(sat_en);
  assign ch_ok  = ({1'b0, in_ch} < N_CH_L);
  assign accept = in_valid && !clr && ch_ok;

  // out-of-range tags never reach the arrays; the mux falls back to channel 0
  always_comb begin
    sel_acc   = acc_q[0];
    win_close = 1'b0;
    if (ch_ok) begin
      sel_acc   = acc_q[in_ch];
      win_close = (cnt_q[in_ch] == WIN_LAST);
    end
  end

  acc_sat_add #(
    .IN_W  (IN_W),
    .SUM_W (SUM_W)
  ) u_add (
    .acc      (sel_acc),
    .sample   (in),
    .mode     (mode),
    .result   (add_res),
    .overflow (add_ovf)
  );

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    wovf_d      = wovf_q;
    sticky_d    = sticky_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;

    if (clr) begin
      for (int i = 0; i < N_CH; i++) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end
      wovf_d   = '0;
      sticky_d = '0;
    end else if (accept) begin
      sticky_d[in_ch] = sticky_q[in_ch] | add_ovf;
      if (win_close) begin
        out_valid_d   = 1'b1;
        out_ch_d      = in_ch;
        sum_d         = add_res;
        ovf_d         = wovf_q[in_ch] | add_ovf;
        acc_d[in_ch]  = '0;
        cnt_d[in_ch]  = '0;
        wovf_d[in_ch] = 1'b0;
      end else begin
        acc_d[in_ch]  = add_res;
        cnt_d[in_ch]  = cnt_q[in_ch] + CNT_W'(1);
        wovf_d[in_ch] = wovf_q[in_ch] | add_ovf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      wovf_q      <= '0;
      sticky_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      wovf_q      <= wovf_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign sum        = sum_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule
